br_4_tdm_demux_14: RTL and testbench



---
 rtl/br_4_tdm_demux_14.sv | 127 ++++++++++++
 tb/tb_br_4_tdm_demux_14.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/br_4_tdm_demux_14.sv
// rtl/br_4_tdm_demux_14.sv - TDM 4:1 receive demux with atomic per-frame output bank
module br_4_tdm_demux_14 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] A0,
  output logic [WIDTH-1:0] A1,
  output logic [WIDTH-1:0] A2,
  output logic [WIDTH-1:0] A3,
  output logic             frame_done,
  output logic             locked,
  output logic             sync_err,
  output logic [1:0]       slot
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t state, state_n;

  // Shadow bank holds slots 0..2; slot 3 goes straight from din to A3.
  logic [WIDTH-1:0] sh0, sh1, sh2;
  logic [WIDTH-1:0] sh0_n, sh1_n, sh2_n;
  logic [WIDTH-1:0] a0_n, a1_n, a2_n, a3_n;
  logic [1:0]       slot_n;
  logic             done_n, err_n;

  assign locked = (state == LOCKED);

  // State, shadow bank, output bank and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      slot       <= 2'd0;
      sh0        <= '0;
      sh1        <= '0;
      sh2        <= '0;
      A0         <= '0;
      A1         <= '0;
      A2         <= '0;
      A3         <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_n;
      slot       <= slot_n;
      sh0        <= sh0_n;
      sh1        <= sh1_n;
      sh2        <= sh2_n;
      A0         <= a0_n;
      A1         <= a1_n;
      A2         <= a2_n;
      A3         <= a3_n;
      frame_done <= done_n;
      sync_err   <= err_n;
    end
  end

  // Next-state: alignment tracking, slot capture and whole-frame commit.
  always_comb begin
    state_n = state;
    slot_n  = slot;
    sh0_n   = sh0;
    sh1_n   = sh1;
    sh2_n   = sh2;
    a0_n    = A0;
    a1_n    = A1;
    a2_n    = A2;
    a3_n    = A3;
    done_n  = 1'b0;
    err_n   = 1'b0;
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (frame_sync) begin
            sh0_n   = din;
            slot_n  = 2'd1;
            state_n = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // Sync anywhere but slot 0 aborts the partial frame and restarts it.
            err_n  = (slot != 2'd0);
            sh0_n  = din;
            slot_n = 2'd1;
          end else begin
            case (slot)
              2'd0: begin
                err_n   = 1'b1;
                state_n = HUNT;
                slot_n  = 2'd0;
              end
              2'd1: begin
                sh1_n  = din;
                slot_n = 2'd2;
              end
              2'd2: begin
                sh2_n  = din;
                slot_n = 2'd3;
              end
              default: begin
                a0_n   = sh0;
                a1_n   = sh1;
                a2_n   = sh2;
                a3_n   = din;
                done_n = 1'b1;
                slot_n = 2'd0;
              end
            endcase
          end
        end
        default: begin
          state_n = HUNT;
          slot_n  = 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_br_4_tdm_demux_14.sv
// tb/tb_br_4_tdm_demux_14.sv - randomized self-checking bench for br_4_tdm_demux_14
module tb_br_4_tdm_demux_14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = '0;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic [3:0] A0, A1, A2, A3;
  logic       frame_done, locked, sync_err;
  logic [1:0] slot;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: words of the frame being collected, in arrival order.
  logic [3:0] m_q[$];
  logic       m_locked = 1'b0;
  logic [3:0] m_a[4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic       m_done = 1'b0;
  logic       m_err  = 1'b0;
  logic [1:0] m_slot;

  assign m_slot = m_locked ? 2'(m_q.size()) : 2'd0;

  br_4_tdm_demux_14 #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .A0(A0), .A1(A1), .A2(A2), .A3(A3),
    .frame_done(frame_done), .locked(locked), .sync_err(sync_err), .slot(slot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_locked = 1'b0;
    for (int i = 0; i < 4; i++) m_a[i] = 4'd0;
    m_done = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic fs, input logic [3:0] d);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (fs) begin
          m_q.delete();
          m_q.push_back(d);
          m_locked = 1'b1;
        end
      end else if (fs) begin
        m_err = (m_q.size() != 0);
        m_q.delete();
        m_q.push_back(d);
      end else if (m_q.size() == 0) begin
        m_err    = 1'b1;
        m_locked = 1'b0;
      end else begin
        m_q.push_back(d);
        if (m_q.size() == 4) begin
          for (int i = 0; i < 4; i++) m_a[i] = m_q[i];
          m_done = 1'b1;
          m_q.delete();
        end
      end
    end
  endtask

  // One clock: drive inputs, advance model on the edge, leave sampling point 1ns later.
  task automatic step(input logic v, input logic fs, input logic [3:0] d);
    din_valid  = v;
    frame_sync = fs;
    din        = d;
    @(posedge clk);
    if (!rst) model_step(v, fs, d);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] w0, w1, w2, w3);
    step(1'b1, 1'b1, w0);
    step(1'b1, 1'b0, w1);
    step(1'b1, 1'b0, w2);
    step(1'b1, 1'b0, w3);
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("A0", int'(A0), int'(m_a[0]));
    chk("A1", int'(A1), int'(m_a[1]));
    chk("A2", int'(A2), int'(m_a[2]));
    chk("A3", int'(A3), int'(m_a[3]));
    chk("frame_done", int'(frame_done), int'(m_done));
    chk("sync_err", int'(sync_err), int'(m_err));
    chk("locked", int'(locked), int'(m_locked));
    chk("slot", int'(slot), int'(m_slot));
    chk("done_err_excl", int'(frame_done & sync_err), 0);
  end

  initial begin
    int cnt;
    logic v, fs;
    model_reset();
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst_A0", int'(A0), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_slot", int'(slot), 0);

    // Single frame.
    send_frame(4'h1, 4'h2, 4'h4, 4'h8);
    chk("f1_A0", int'(A0), 1);
    chk("f1_A1", int'(A1), 2);
    chk("f1_A2", int'(A2), 4);
    chk("f1_A3", int'(A3), 8);
    chk("f1_done", int'(frame_done), 1);
    chk("f1_locked", int'(locked), 1);
    chk("f1_slot", int'(slot), 0);
    step(1'b0, 1'b0, 4'h0);
    chk("f1_done_drop", int'(frame_done), 0);

    // Back-to-back frames.
    send_frame(4'h1, 4'h2, 4'h4, 4'h8);
    chk("b2b_done1", int'(frame_done), 1);
    step(1'b1, 1'b1, 4'hF);
    chk("b2b_hold_A0", int'(A0), 1);
    chk("b2b_done_mid", int'(frame_done), 0);
    step(1'b1, 1'b0, 4'hE);
    step(1'b1, 1'b0, 4'hD);
    step(1'b1, 1'b0, 4'hC);
    chk("b2b_done2", int'(frame_done), 1);
    chk("b2b_A0", int'(A0), 15);
    chk("b2b_A3", int'(A3), 12);

    // Idle gaps between words.
    step(1'b1, 1'b1, 4'h1);
    repeat (3) step(1'b0, 1'b0, 4'h9);
    chk("gap_slot", int'(slot), 1);
    step(1'b1, 1'b0, 4'h2);
    repeat (3) step(1'b0, 1'b1, 4'h9);
    step(1'b1, 1'b0, 4'h4);
    chk("gap_no_done", int'(frame_done), 0);
    step(1'b1, 1'b0, 4'h8);
    chk("gap_done", int'(frame_done), 1);
    chk("gap_A1", int'(A1), 2);

    // Early sync at slot 2.
    step(1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b0, 4'h2);
    step(1'b1, 1'b1, 4'h7);
    chk("early_err", int'(sync_err), 1);
    chk("early_slot", int'(slot), 1);
    chk("early_locked", int'(locked), 1);
    step(1'b1, 1'b0, 4'h3);
    chk("early_err_drop", int'(sync_err), 0);
    step(1'b1, 1'b0, 4'h5);
    step(1'b1, 1'b0, 4'h9);
    chk("early_A0", int'(A0), 7);
    chk("early_A1", int'(A1), 3);
    chk("early_A2", int'(A2), 5);
    chk("early_A3", int'(A3), 9);

    // Missing sync at slot 0.
    step(1'b1, 1'b0, 4'h6);
    chk("miss_err", int'(sync_err), 1);
    chk("miss_locked", int'(locked), 0);
    chk("miss_A0", int'(A0), 7);
    step(1'b1, 1'b0, 4'hA);
    step(1'b1, 1'b0, 4'hB);
    chk("miss_ignored_err", int'(sync_err), 0);
    chk("miss_ignored_slot", int'(slot), 0);

    // Asynchronous reset mid-frame.
    step(1'b1, 1'b1, 4'hD);
    step(1'b1, 1'b0, 4'hE);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("arst_A0", int'(A0), 0);
    chk("arst_A3", int'(A3), 0);
    chk("arst_locked", int'(locked), 0);
    chk("arst_slot", int'(slot), 0);
    step(1'b0, 1'b0, 4'h0);
    #4 rst = 1'b0;
    send_frame(4'h1, 4'h2, 4'h4, 4'h8);
    chk("arst_f_A0", int'(A0), 1);
    chk("arst_f_A1", int'(A1), 2);
    chk("arst_f_A2", int'(A2), 4);
    chk("arst_f_A3", int'(A3), 8);

    // Randomized stream with occasional sync faults and idles.
    cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      fs = ((cnt % 4) == 0) ^ ($urandom_range(0, 15) == 0);
      step(v, fs, 4'($urandom));
      if (v) cnt++;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
